// File: rtl/seg_display_pkg.sv
// Shared constants and scan state encoding for the 7-segment scan controller.
package seg_display_pkg;

    localparam logic [3:0] BCD_BLANK = 4'hF;
    localparam logic [3:0] BCD_MAX   = 4'd9;

    typedef enum logic {
        DRIVE = 1'b0,
        DEAD  = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seg_display_scan_ctrl_timer.sv
// Per-digit slot timer: dwell counter plus DRIVE/DEAD sequencing for one digit slot.
module seg_scan_timer #(
    parameter int CLKS_PER_DIGIT = 100000,
    parameter int DEAD_CLKS      = 500
) (
    input  logic clk,
    input  logic rst_n,
    output logic slot_end,
    output logic in_drive
);
    import seg_display_pkg::*;

    localparam int CNT_W      = (CLKS_PER_DIGIT > 1) ? $clog2(CLKS_PER_DIGIT) : 1;
    localparam int DRIVE_CLKS = CLKS_PER_DIGIT - DEAD_CLKS;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_next;
    scan_state_t      state_q;
    scan_state_t      state_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            state_q <= DRIVE;
        end else begin
            cnt_q   <= cnt_next;
            state_q <= state_next;
        end
    end

    // The counter spans the whole slot; DEAD occupies its last DEAD_CLKS counts.
    always_comb begin
        slot_end   = (cnt_q == CNT_W'(CLKS_PER_DIGIT - 1));
        in_drive   = (state_q == DRIVE);
        cnt_next   = slot_end ? '0 : cnt_q + CNT_W'(1);
        state_next = state_q;
        case (state_q)
            DRIVE:   if (cnt_q == CNT_W'(DRIVE_CLKS - 1)) state_next = DEAD;
            DEAD:    if (slot_end) state_next = DRIVE;
            default: state_next = DRIVE;
        endcase
    end

endmodule

// File: rtl/seg_display_scan_ctrl.sv
// Multiplexed HH:MM display scanner driving an external registered BCD decoder.
// Optional blink support is compiled in with the SEG_SCAN_BLINK_EN macro.
module seg_display_scan_ctrl #(
    parameter int NUM_DIGITS     = 4,
    parameter int CLKS_PER_DIGIT = 100000,
    parameter int DEAD_CLKS      = 500,
    parameter int BLINK_CLKS     = 25000000
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_n,
    input  logic                    i_Load,
    input  logic [4*NUM_DIGITS-1:0] i_Digits,
    input  logic                    i_LZ_Blank_En,
    input  logic [NUM_DIGITS-1:0]   i_Blink_Mask,
    output logic [3:0]              o_BCD_Num,
    output logic [NUM_DIGITS-1:0]   o_Anodes,
    output logic                    o_Busy,
    output logic                    o_Frame_Done
);
    import seg_display_pkg::*;

    localparam int               IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int               DW       = 4 * NUM_DIGITS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic                  slot_end;
    logic                  in_drive;
    logic                  frame_done;
    logic [IDX_W-1:0]      idx_q;
    logic [IDX_W-1:0]      idx_next;
    logic [DW-1:0]         active_q;
    logic [DW-1:0]         active_next;
    logic [DW-1:0]         pending_q;
    logic                  busy_q;
    logic                  phase_q;
    logic                  phase_next;
    logic                  blank_cur;
    logic                  blank_next;
    logic [NUM_DIGITS-1:0] digit_sel;
    logic [3:0]            bcd_q;
    logic [NUM_DIGITS-1:0] anodes_q;

    function automatic logic digit_blank(input logic [DW-1:0]         digits,
                                         input logic [IDX_W-1:0]      k,
                                         input logic                  lz_en,
                                         input logic                  phase,
                                         input logic [NUM_DIGITS-1:0] mask);
        logic upper_zero;
        upper_zero = 1'b1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (j >= int'(k) && digits[4*j +: 4] != 4'd0) upper_zero = 1'b0;
        end
        return (digits[4*k +: 4] > BCD_MAX) || (lz_en && k != '0 && upper_zero) ||
               (!phase && mask[k]);
    endfunction

    seg_scan_timer #(
        .CLKS_PER_DIGIT(CLKS_PER_DIGIT),
        .DEAD_CLKS     (DEAD_CLKS)
    ) u_timer (
        .clk     (i_Clk),
        .rst_n   (i_Rst_n),
        .slot_end(slot_end),
        .in_drive(in_drive)
    );

`ifdef SEG_SCAN_BLINK_EN
    localparam int BLINK_W = (BLINK_CLKS > 1) ? $clog2(BLINK_CLKS) : 1;

    logic [BLINK_W-1:0] blink_cnt_q;
    logic               raw_phase_q;

    // Free-running phase; the displayed phase only follows it at slot boundaries.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            blink_cnt_q <= '0;
            raw_phase_q <= 1'b1;
            phase_q     <= 1'b1;
        end else begin
            phase_q <= phase_next;
            if (blink_cnt_q == BLINK_W'(BLINK_CLKS - 1)) begin
                blink_cnt_q <= '0;
                raw_phase_q <= ~raw_phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
            end
        end
    end

    assign phase_next = slot_end ? raw_phase_q : phase_q;
`else
    localparam int unused_blink_clks = BLINK_CLKS;

    assign phase_q    = 1'b1;
    assign phase_next = 1'b1;
`endif

    // Frame-wrap commit: a load on the wrap cycle itself bypasses the pending register.
    always_comb begin
        frame_done  = slot_end && (idx_q == LAST_IDX);
        idx_next    = idx_q;
        active_next = active_q;
        if (slot_end) idx_next = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        if (frame_done) begin
            if (i_Load)      active_next = i_Digits;
            else if (busy_q) active_next = pending_q;
        end
        digit_sel  = NUM_DIGITS'(1) << idx_q;
        blank_cur  = digit_blank(active_q, idx_q, i_LZ_Blank_En, phase_q, i_Blink_Mask);
        blank_next = digit_blank(active_next, idx_next, i_LZ_Blank_En, phase_next, i_Blink_Mask);
    end

    // BCD is registered from next-cycle state so it lines up with the slot start;
    // anodes follow one cycle behind to match the decoder latency.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            idx_q     <= '0;
            active_q  <= '0;
            pending_q <= '0;
            busy_q    <= 1'b0;
            bcd_q     <= BCD_BLANK;
            anodes_q  <= '1;
        end else begin
            idx_q    <= idx_next;
            active_q <= active_next;
            if (i_Load) pending_q <= i_Digits;
            if (frame_done)  busy_q <= 1'b0;
            else if (i_Load) busy_q <= 1'b1;
            bcd_q    <= blank_next ? BCD_BLANK : active_next[4*idx_next +: 4];
            anodes_q <= (in_drive && !blank_cur) ? ~digit_sel : '1;
        end
    end

    assign o_BCD_Num    = bcd_q;
    assign o_Anodes     = anodes_q;
    assign o_Busy       = busy_q;
    assign o_Frame_Done = frame_done;

endmodule

// File: tb/tb_seg_display_scan_ctrl.sv
// Directed bench for seg_display_scan_ctrl: table of display vectors plus load/reset corner sequences.
module tb_seg_display_scan_ctrl;

    localparam int ND    = 4;
    localparam int CPD   = 8;
    localparam int DEAD  = 2;
    localparam int BLINK = 64;
    localparam int FRAME = ND * CPD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] digits = 16'h0000;
    logic        lz_en = 1'b0;
    logic [3:0]  blink_mask = 4'b0000;
    logic [3:0]  bcd;
    logic [3:0]  anodes;
    logic        busy;
    logic        frame_done;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic [15:0] digits;
        logic        lz;
        logic [15:0] exp_bcd;
        logic [3:0]  exp_on;
    } vec_t;

    vec_t vecs[7];

    seg_display_scan_ctrl #(
        .NUM_DIGITS    (ND),
        .CLKS_PER_DIGIT(CPD),
        .DEAD_CLKS     (DEAD),
        .BLINK_CLKS    (BLINK)
    ) dut (
        .i_Clk        (clk),
        .i_Rst_n      (rst_n),
        .i_Load       (load),
        .i_Digits     (digits),
        .i_LZ_Blank_En(lz_en),
        .i_Blink_Mask (blink_mask),
        .o_BCD_Num    (bcd),
        .o_Anodes     (anodes),
        .o_Busy       (busy),
        .o_Frame_Done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_frame_done(input string name);
        int n;
        n = 0;
        while (!frame_done && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check_output({name, " frame_done reached"}, 16'(frame_done), 16'd1);
    endtask

    // Called at the wrap-cycle negedge; checks every cycle of the following frame.
    task automatic run_frame(input string name, input logic [15:0] exp_bcd, input logic [3:0] exp_on);
        int k;
        int c;
        logic [3:0] exp_an;
        for (int f = 0; f < FRAME; f++) begin
            @(negedge clk);
            load = 1'b0;
            k = f / CPD;
            c = f % CPD;
            exp_an = 4'hF;
            if (c >= 1 && c <= CPD - DEAD && exp_on[k]) exp_an[k] = 1'b0;
            check_output($sformatf("%s f%0d bcd", name, f), 16'(bcd), 16'(exp_bcd[4*k +: 4]));
            check_output($sformatf("%s f%0d anodes", name, f), 16'(anodes), 16'(exp_an));
            check_output($sformatf("%s f%0d busy", name, f), 16'(busy), 16'd0);
            check_output($sformatf("%s f%0d frame_done", name, f), 16'(frame_done),
                         16'(f == FRAME - 1));
        end
    endtask

    // Issue a load away from the wrap and follow it to its commit point.
    task automatic apply_stimulus(input string name, input logic [15:0] d, input logic lz);
        lz_en  = lz;
        digits = d;
        load   = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check_output({name, " busy after load"}, 16'(busy), 16'd1);
        wait_frame_done(name);
        check_output({name, " busy at wrap"}, 16'(busy), 16'd1);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cycles;
        int on_cnt[4];

        vecs[0] = '{16'h1234, 1'b0, 16'h1234, 4'b1111};
        vecs[1] = '{16'h0005, 1'b1, 16'hFFF5, 4'b0001};
        vecs[2] = '{16'h0000, 1'b1, 16'hFFF0, 4'b0001};
        vecs[3] = '{16'h12A4, 1'b0, 16'h12F4, 4'b1101};
        vecs[4] = '{16'h0005, 1'b0, 16'h0005, 4'b1111};
        vecs[5] = '{16'h0105, 1'b1, 16'hF105, 4'b0111};
        vecs[6] = '{16'h9B09, 1'b1, 16'h9F09, 4'b1011};

        repeat (3) @(negedge clk);
        check_output("reset anodes", 16'(anodes), 16'hF);
        check_output("reset bcd", 16'(bcd), 16'hF);
        check_output("reset busy", 16'(busy), 16'd0);
        check_output("reset frame_done", 16'(frame_done), 16'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            apply_stimulus($sformatf("vec%0d", i), vecs[i].digits, vecs[i].lz);
            run_frame($sformatf("vec%0d", i), vecs[i].exp_bcd, vecs[i].exp_on);
            @(negedge clk);
        end

        // Two loads in one frame: only the second may ever reach the display.
        digits = 16'h1111;
        load   = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check_output("last_wins busy first load", 16'(busy), 16'd1);
        repeat (10) begin
            @(negedge clk);
            check_output("last_wins no tearing", 16'(bcd == 4'h1), 16'd0);
        end
        digits = 16'h2222;
        load   = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check_output("last_wins busy second load", 16'(busy), 16'd1);
        wait_frame_done("last_wins");
        check_output("last_wins busy at wrap", 16'(busy), 16'd1);
        run_frame("last_wins", 16'h2222, 4'b1111);
        @(negedge clk);

        // Load presented exactly on the wrap cycle commits immediately without busy.
        wait_frame_done("wrap_load");
        digits = 16'h5678;
        load   = 1'b1;
        run_frame("wrap_load", 16'h5678, 4'b1111);
        @(negedge clk);

        // Reset in the middle of digit 0's drive window with a load pending.
        lz_en = 1'b0;
        repeat (3) @(negedge clk);
        digits = 16'h4321;
        load   = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check_output("midreset busy before", 16'(busy), 16'd1);
        check_output("midreset anodes before", 16'(anodes), 16'hE);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("midreset anodes", 16'(anodes), 16'hF);
        check_output("midreset bcd", 16'(bcd), 16'hF);
        check_output("midreset busy", 16'(busy), 16'd0);
        check_output("midreset frame_done", 16'(frame_done), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("postreset bcd", 16'(bcd), 16'h0);
        check_output("postreset anodes", 16'(anodes), 16'hE);
        check_output("postreset busy", 16'(busy), 16'd0);
        cycles = 0;
        while (!frame_done && cycles < 2 * FRAME) begin
            @(negedge clk);
            cycles++;
        end
        check_output("postreset cycles to wrap", 16'(cycles), 16'(FRAME - 2));
        run_frame("postreset", 16'h0000, 4'b1111);
        @(negedge clk);

`ifdef SEG_SCAN_BLINK_EN
        blink_mask = 4'b0011;
        apply_stimulus("blink", 16'h1234, 1'b0);
        for (int b = 0; b < 4; b++) on_cnt[b] = 0;
        for (int f = 0; f < 8 * FRAME; f++) begin
            @(negedge clk);
            for (int b = 0; b < 4; b++) if (!anodes[b]) on_cnt[b]++;
        end
        check_output("blink digit0 on cycles", 16'(on_cnt[0]), 16'(4 * (CPD - DEAD)));
        check_output("blink digit1 on cycles", 16'(on_cnt[1]), 16'(4 * (CPD - DEAD)));
        check_output("blink digit2 on cycles", 16'(on_cnt[2]), 16'(8 * (CPD - DEAD)));
        check_output("blink digit3 on cycles", 16'(on_cnt[3]), 16'(8 * (CPD - DEAD)));
`else
        for (int b = 0; b < 4; b++) on_cnt[b] = 0;
        blink_mask = 4'b0011;
        apply_stimulus("mask_ignored", 16'h1234, 1'b0);
        run_frame("mask_ignored", 16'h1234, 4'b1111);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
